// File: rtl/stream_pkg.sv
// stream_pkg: shared constants, index-width helper and FSM state encoding for the stream arbiter
package stream_pkg;
    localparam int DEF_N       = 4;
    localparam int DEF_LEN     = 8;
    localparam int DEF_TIMEOUT = 15;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int IDX_W = idx_w(DEF_N);
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority encoder, first set req scanning last_grant+1, +2, ... modulo N
//   req        : per-requester request bits
//   last_grant : index that won most recently (lowest priority now)
//   idx        : chosen index, 0 when nothing requests
//   any        : at least one request is set
module rr_pick
    import stream_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   last_grant,
    output logic [idx_w(N)-1:0]   idx,
    output logic                  any
);
    localparam int W = idx_w(N);
    logic [W-1:0] j;
    // Scanning from the farthest offset down lets the nearest requester overwrite.
    always_comb begin
        idx = '0;
        j   = '0;
        for (int k = N; k >= 1; k--) begin
            j = W'((int'(last_grant) + k) % N);
            if (req[j]) idx = j;
        end
    end
    assign any = |req;
endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-granular round-robin merge of N valid/ready/last streams with stall watchdog
//   s_valid/s_last/s_data/s_ready : per-source stream, source i data at s_data[i*LEN +: LEN]
//   m_valid/m_last/m_data/m_ready : merged downstream stream
//   grant_id    : current owner, meaningful while busy
//   busy        : a grant is held
//   timeout_err : one-cycle pulse on the cycle the watchdog revokes a grant
module stream_rr_arbiter
    import stream_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int LEN     = DEF_LEN,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          s_valid,
    input  logic [N-1:0]          s_last,
    input  logic [N*LEN-1:0]      s_data,
    output logic [N-1:0]          s_ready,
    output logic                  m_valid,
    output logic                  m_last,
    output logic [LEN-1:0]        m_data,
    input  logic                  m_ready,
    output logic [idx_w(N)-1:0]   grant_id,
    output logic                  busy,
    output logic                  timeout_err
);
    localparam int W = idx_w(N);
    state_e       state_q, state_d;
    logic [W-1:0] grant_q, grant_d, last_q, last_d, pick_idx;
    logic [7:0]   stall_q, stall_d, stall_inc;
    logic         pick_any, vg, done, tmo;
    rr_pick #(.N(N)) u_pick (
        .req        (s_valid),
        .last_grant (last_q),
        .idx        (pick_idx),
        .any        (pick_any)
    );
    always_comb begin
        busy      = state_q == ST_BUSY;
        vg        = s_valid[grant_q];
        m_valid   = busy && vg;
        m_last    = busy && s_last[grant_q];
        m_data    = '0;
        s_ready   = '0;
        for (int i = 0; i < N; i++) begin
            m_data     = (busy && grant_q == W'(i)) ? s_data[i*LEN +: LEN] : m_data;
            s_ready[i] = busy && m_ready && grant_q == W'(i);
        end
        done      = m_valid && m_ready && m_last;
        stall_inc = (stall_q == 8'hFF) ? stall_q : stall_q + 8'd1;
        // The revoke fires on the stalled cycle that brings the count to TIMEOUT.
        tmo       = busy && !vg && stall_inc == 8'(TIMEOUT);
        timeout_err = tmo;
        state_d   = busy ? ((done || tmo) ? ST_IDLE : ST_BUSY) : (pick_any ? ST_BUSY : ST_IDLE);
        grant_d   = (!busy && pick_any) ? pick_idx : grant_q;
        last_d    = (done || tmo) ? grant_q : last_q;
        stall_d   = (busy && !vg && !tmo) ? stall_inc : '0;
    end
    assign grant_id = grant_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= W'(N - 1);
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: table-driven and sequence checks of stream_rr_arbiter with a beat scoreboard
module tb_stream_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_valid = '0, s_last = '0, s_ready;
    logic [31:0] s_data = '0;
    logic        m_valid, m_last, m_ready = 1'b0, busy, timeout_err;
    logic [7:0]  m_data;
    logic [1:0]  grant_id;
    logic [2:0]  v3 = '0, l3 = '0, sr3;
    logic [23:0] d3 = '0;
    logic        r3 = 1'b0, mv3, ml3, b3, to3;
    logic [7:0]  md3;
    logic [1:0]  g3;
    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];
    typedef struct {
        logic [3:0]  vld, lst;
        logic [31:0] dat;
        logic        rdy, e_busy;
        logic [1:0]  e_gid;
        logic        e_mv, e_ml;
        logic [7:0]  e_md;
        logic [3:0]  e_sr;
    } vec_t;
    vec_t vec[16];

    always #5 clk = ~clk;

    stream_rr_arbiter #(.N(4), .LEN(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_last(s_last), .s_data(s_data),
        .s_ready(s_ready), .m_valid(m_valid), .m_last(m_last), .m_data(m_data),
        .m_ready(m_ready), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );
    stream_rr_arbiter #(.N(3), .LEN(8), .TIMEOUT(15)) dut3 (
        .clk(clk), .rst(rst), .s_valid(v3), .s_last(l3), .s_data(d3),
        .s_ready(sr3), .m_valid(mv3), .m_last(ml3), .m_data(md3),
        .m_ready(r3), .grant_id(g3), .busy(b3), .timeout_err(to3)
    );

    task automatic chk(input string n, input int tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", n, tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic r);
        s_valid = v;
        s_last  = l;
        s_data  = d;
        m_ready = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'h0, 4'h0, 32'h0, 1'b0);
        v3 = '0;
        r3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vec[i].vld, vec[i].lst, vec[i].dat, vec[i].rdy);
            #1;
            chk("busy", i, busy, vec[i].e_busy);
            chk("m_valid", i, m_valid, vec[i].e_mv);
            chk("s_ready", i, s_ready, vec[i].e_sr);
            chk("timeout_err", i, timeout_err, 0);
            if (vec[i].e_busy) chk("grant_id", i, grant_id, vec[i].e_gid);
            if (vec[i].e_mv) begin
                chk("m_data", i, m_data, vec[i].e_md);
                chk("m_last", i, m_last, vec[i].e_ml);
            end
            if (vec[i].e_mv && vec[i].rdy) sb.push_back({vec[i].e_ml, vec[i].e_md});
            step();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got beat %0h expected none", {m_last, m_data});
            end else begin
                chk("sb_beat", 0, {m_last, m_data}, sb.pop_front());
            end
        end
    end

    initial begin
        int exp_g, ngr;
        // round robin over four 1-beat requesters
        vec[0]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0};
        vec[1]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 8'h10, 4'h1};
        vec[2]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0};
        vec[3]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 8'h11, 4'h2};
        vec[4]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0};
        vec[5]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 8'h12, 4'h4};
        vec[6]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0};
        vec[7]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 8'h13, 4'h8};
        vec[8]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0};
        vec[9]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 8'h10, 4'h1};
        // source 2 three-beat packet, source 1 joins at beat 2
        vec[10] = '{4'h4, 4'h0, 32'h00A00000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0};
        vec[11] = '{4'h4, 4'h0, 32'h00A00000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 8'hA0, 4'h4};
        vec[12] = '{4'h6, 4'h0, 32'h00A15500, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 8'hA1, 4'h4};
        vec[13] = '{4'h6, 4'h4, 32'h00A25500, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 8'hA2, 4'h4};
        vec[14] = '{4'h2, 4'h0, 32'h00005500, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0};
        vec[15] = '{4'h2, 4'h0, 32'h00005500, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 8'h55, 4'h2};

        do_reset();
        chk("rst_busy", 0, busy, 0);
        chk("rst_grant", 0, grant_id, 0);
        chk("rst_m_valid", 0, m_valid, 0);
        chk("rst_m_last", 0, m_last, 0);
        chk("rst_m_data", 0, m_data, 0);
        chk("rst_s_ready", 0, s_ready, 0);
        chk("rst_timeout", 0, timeout_err, 0);
        run_table(0, 9);
        do_reset();
        run_table(10, 15);

        // backpressure for 20 cycles must not trip the watchdog
        do_reset();
        drive(4'h1, 4'h1, 32'h00000055, 1'b0);
        #1;
        chk("bp_idle", 0, busy, 0);
        step();
        for (int k = 0; k < 20; k++) begin
            chk("bp_valid", k, m_valid, 1);
            chk("bp_data", k, m_data, 8'h55);
            chk("bp_timeout", k, timeout_err, 0);
            chk("bp_ready", k, s_ready, 0);
            step();
        end
        m_ready = 1'b1;
        sb.push_back({1'b1, 8'h55});
        #1;
        chk("bp_release_ready", 0, s_ready, 1);
        step();
        drive(4'h0, 4'h0, 32'h0, 1'b1);
        #1;
        chk("bp_done", 0, busy, 0);

        // watchdog revokes source 3 after 15 stalled cycles
        do_reset();
        drive(4'h8, 4'h0, 32'h33000000, 1'b1);
        #1;
        chk("wd_idle", 0, busy, 0);
        step();
        chk("wd_grant", 0, grant_id, 3);
        chk("wd_data", 0, m_data, 8'h33);
        sb.push_back({1'b0, 8'h33});
        step();
        for (int k = 1; k <= 15; k++) begin
            drive(4'h0, 4'h0, 32'h0, 1'b1);
            #1;
            chk("wd_busy", k, busy, 1);
            chk("wd_pulse", k, timeout_err, (k == 15) ? 1 : 0);
            step();
        end
        drive(4'h9, 4'h9, 32'h30000030, 1'b0);
        #1;
        chk("wd_revoked", 0, busy, 0);
        chk("wd_pulse_end", 0, timeout_err, 0);
        step();
        chk("wd_next_busy", 0, busy, 1);
        chk("wd_next_grant", 0, grant_id, 0);

        // asynchronous reset between clock edges
        do_reset();
        drive(4'h2, 4'h0, 32'h00007700, 1'b1);
        #1;
        chk("ar_idle", 0, busy, 0);
        step();
        chk("ar_busy", 0, busy, 1);
        chk("ar_ready", 0, s_ready, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy_now", 0, busy, 0);
        chk("ar_valid_now", 0, m_valid, 0);
        chk("ar_ready_now", 0, s_ready, 0);
        step();
        rst = 1'b0;
        drive(4'hA, 4'hA, 32'h0, 1'b0);
        #1;
        chk("ar_post_idle", 0, busy, 0);
        step();
        chk("ar_post_busy", 0, busy, 1);
        chk("ar_post_grant", 0, grant_id, 1);

        // N=3 instance alternates between sources 0 and 2
        do_reset();
        v3 = 3'b101;
        l3 = 3'b111;
        d3 = 24'h220011;
        r3 = 1'b1;
        exp_g = 0;
        ngr = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk("n3_range", k, (g3 <= 2'd2), 1);
            if (b3) begin
                chk("n3_grant", k, g3, exp_g);
                chk("n3_data", k, md3, (exp_g == 0) ? 8'h11 : 8'h22);
                exp_g = (exp_g == 0) ? 2 : 0;
                ngr++;
            end
            step();
        end
        chk("n3_count", 0, ngr, 6);

        chk("sb_empty", 0, sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that merges N valid/ready/last byte streams, such as random traffic sources, onto one downstream sink.
- A grant is held from the first beat until the beat carrying last completes its handshake.
- A stall watchdog revokes a grant whose owner stops presenting valid mid-packet, so one stalled source cannot block the shared sink.
- Sits between a bank of stream sources and a single consumer.

Parameters:
- N, 4, number of requesting sources (2..8).
- LEN, 8, data width per beat.
- TIMEOUT, 15, max consecutive cycles the granted source may hold valid low mid-packet before the grant is revoked (1..255).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- s_valid  in  N  per-source valid.
- s_last  in  N  per-source last.
- s_data  in  N*LEN  per-source data, source i at bits [i*LEN +: LEN].
- s_ready  out  N  per-source ready.
- m_valid  out  1  downstream valid.
- m_last  out  1  downstream last.
- m_data  out  LEN  downstream data.
- m_ready  in  1  downstream ready.
- grant_id  out  $clog2(N)  index of current owner, valid while busy.
- busy  out  1  a grant is held.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by the watchdog.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, grant_id=0, last_grant=N-1 so source 0 has first priority.
  - stall_cnt=0, busy=0, timeout_err=0.
  - s_ready=0, m_valid=0, m_last=0, m_data=0.
- Asserting rst mid-packet aborts the packet immediately. There is no flush; the next packet starts with fresh arbitration.
- States are IDLE and BUSY.
- IDLE:
  - s_ready=0 and m_valid=0.
  - If any s_valid bit is set, pick the first set index scanning last_grant+1, last_grant+2, ... with wrap modulo N.
  - Register it as grant_id and go to BUSY.
  - Arbitration latency is 1 cycle from request to forwarding.
- BUSY, combinational forward from grant_id:
  - m_valid=s_valid[g], m_last=s_last[g], m_data=s_data[g].
  - s_ready[g]=m_ready; all other s_ready bits are 0.
- A transfer occurs when m_valid && m_ready.
- A transfer with m_last=1 ends the packet:
  - last_grant<=g, state<=IDLE.
  - One bubble cycle follows before the next grant.
- m_data is don't-care when m_valid=0. Sources must hold data and last stable while valid && !ready.
- Watchdog:
  - In BUSY, stall_cnt increments each cycle s_valid[g]=0 and clears on any cycle s_valid[g]=1.
  - stall_cnt saturates at 8 bits.
  - When stall_cnt==TIMEOUT with valid still low: revoke the grant, pulse timeout_err for 1 cycle, set last_grant<=g, go to IDLE.
  - The rest of that source's packet is then arbitrated as a new packet.
- Downstream backpressure (m_ready=0 while valid=1) never advances the watchdog.
- Single requester: it is re-granted after each bubble cycle.
- A requester whose valid drops while in IDLE before being picked simply loses that cycle. No request latching.
- Simultaneous last-transfer and rising requests: the requests are seen in IDLE on the next cycle, under the updated last_grant.
- N not a power of two: grant_id never exceeds N-1.

Decomposition:
- Shared package stream_pkg holds:
  - index width function/constant IDX_W=$clog2(N).
  - state encoding localparams ST_IDLE=1'b0, ST_BUSY=1'b1.
  - default TIMEOUT.
- One sub-module: rr_pick.
  - Combinational rotate-priority encoder with inputs req[N] and last_grant, outputs idx and any.
  - Reusable for other resource arbiters.
- The FSM, mux and watchdog stay in the top module.

Test Plan:
- After reset, s_valid=4'b1111, each source sends a 1-beat packet with data=0x10+i and m_ready=1.
  - Required: m_data sequence 0x10, 0x11, 0x12, 0x13, 0x10.
  - Required: one idle cycle between grants; grant_id 0, 1, 2, 3, 0.
- Source 2 alone sends a 3-beat packet (0xA0, 0xA1, 0xA2 with last) while source 1 asserts valid at beat 2.
  - Required: source 1 is not granted until the cycle after 0xA2 transfers.
  - Required: s_ready[1]=0 throughout.
- Granted source 0 presents a valid beat while m_ready=0 for 20 cycles, then m_ready=1.
  - Required: no timeout_err; beat transfers intact; m_data is stable throughout.
- Granted source 3 sends one non-last beat, then holds valid low with TIMEOUT=15.
  - Required: timeout_err pulses exactly at the 15th stalled cycle; busy drops the next cycle; next grant scans from source 0.
- rst asserted asynchronously mid-packet, between clock edges.
  - Required: s_ready, m_valid and busy go to 0 immediately, without waiting for a clock edge.
  - Required: after release, the first grant goes to the lowest requesting index.
- N=3 with sources 0 and 2 requesting continuously.
  - Required: grants alternate 0, 2, 0, 2 and grant_id never reads 3.
